// File: rtl/pong_matrix_driver.sv
// pong_matrix_driver
//
// Takes per-frame game-state updates from the pong game core and scans them
// onto an 8x8 LED matrix one row at a time. A single pending slot absorbs
// the next update; it is copied into the display register only at a frame
// boundary, so a frame in progress is never torn.
//
// Optional feature macro: PONG_SCORE_OVERLAY_EN
//   defined   -> in PLAY, row 0 also shows sc1 on bits 3:1 and sc2 on bits 6:4
//   undefined -> row 0 shows the playfield only
//
// Parameters
//   ROW_DIV    sys_clk cycles per scanned row (>= 2)
//   WIN_SCORE  score at which a player has won
//
// Ports
//   sys_clk     clock
//   reset       synchronous, active-high reset
//   upd_valid   game core offers an update
//   upd_ready   driver can accept an update (pending slot empty)
//   ball_x/y    ball column / row
//   pad1_y      top row of left paddle (column 0)
//   pad2_y      top row of right paddle (column 7)
//   sc1, sc2    player scores
//   start_o     opening-screen request
//   row_sel     one-hot active-high row drive
//   col_data    active-high column data, bit c = column c
//   frame_done  one-cycle pulse following each frame boundary
//
// Mode state machine (changes only when a pending update is loaded)
//   state   | meaning
//   IDLE    | no update loaded since reset; matrix dark
//   SPLASH  | opening screen, checkerboard
//   PLAY    | ball and paddles
//   WIN     | winner's half lit, blinking once per frame

module pong_matrix_driver #(
   parameter int ROW_DIV   = 1000,
   parameter int WIN_SCORE = 7
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       upd_valid,
   output logic       upd_ready,
   input  logic [2:0] ball_x,
   input  logic [2:0] ball_y,
   input  logic [2:0] pad1_y,
   input  logic [2:0] pad2_y,
   input  logic [2:0] sc1,
   input  logic [2:0] sc2,
   input  logic       start_o,
   output logic [7:0] row_sel,
   output logic [7:0] col_data,
   output logic       frame_done
);

   localparam int            PW        = $clog2(ROW_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(ROW_DIV - 1);

   typedef struct packed {
      logic       start;
      logic [2:0] sc2;
      logic [2:0] sc1;
      logic [2:0] pad2_y;
      logic [2:0] pad1_y;
      logic [2:0] ball_y;
      logic [2:0] ball_x;
   } game_t;

   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_SPLASH,
      MODE_PLAY,
      MODE_WIN
   } mode_t;

   logic [PW-1:0] presc;
   logic [2:0]    row;
   logic          parity;
   logic          pend_full;
   game_t         pend;
   game_t         disp;
   mode_t         mode;

   logic          row_adv;
   logic          boundary;
   logic          load;
   logic          take;
   logic [2:0]    row_nxt;
   logic          parity_nxt;
   game_t         disp_nxt;
   game_t         incoming;
   mode_t         mode_nxt;
   mode_t         load_mode;
   logic [7:0]    pixels_nxt;
   logic [7:0]    row_sel_nxt;

   function automatic logic has_won(input logic [2:0] score);
      return int'(score) >= WIN_SCORE;
   endfunction

   function automatic mode_t classify(input game_t g);
      if (g.start)
         return MODE_SPLASH;
      else if (has_won(g.sc1) || has_won(g.sc2))
         return MODE_WIN;
      else
         return MODE_PLAY;
   endfunction

   // Paddle spans top..top+2; done in 4 bits so a paddle near the bottom is
   // clipped at row 7 instead of wrapping back onto row 0.
   function automatic logic on_paddle(input logic [2:0] top, input logic [2:0] r);
      logic [3:0] r4;
      logic [3:0] lo;
      r4 = {1'b0, r};
      lo = {1'b0, top};
      return (r4 >= lo) && (r4 <= lo + 4'd2);
   endfunction

   function automatic logic [7:0] row_pixels(input game_t g, input mode_t m,
                                             input logic [2:0] r, input logic par);
      logic [7:0] px;
      px = 8'h00;
      case (m)
         MODE_SPLASH: px = r[0] ? 8'hAA : 8'h55;
         MODE_PLAY: begin
            if (r == g.ball_y)
               px[g.ball_x] = 1'b1;
            if (on_paddle(g.pad1_y, r))
               px[0] = 1'b1;
            if (on_paddle(g.pad2_y, r))
               px[7] = 1'b1;
`ifdef PONG_SCORE_OVERLAY_EN
            if (r == 3'd0)
               px = px | {1'b0, g.sc2, g.sc1, 1'b0};
`endif
         end
         MODE_WIN: begin
            if (!par) begin
               if (has_won(g.sc1))
                  px[3:0] = 4'hF;
               if (has_won(g.sc2))
                  px[7:4] = 4'hF;
            end
         end
         default: px = 8'h00;
      endcase
      return px;
   endfunction

   assign upd_ready = !pend_full;

   always_comb begin
      incoming = '{start:  start_o,
                   sc2:    sc2,
                   sc1:    sc1,
                   pad2_y: pad2_y,
                   pad1_y: pad1_y,
                   ball_y: ball_y,
                   ball_x: ball_x};

      row_adv   = (presc == PRESC_MAX);
      boundary  = row_adv && (row == 3'd7);
      load      = boundary && pend_full;
      take      = upd_valid && !pend_full;
      load_mode = classify(pend);

      row_nxt    = row_adv ? row + 3'd1 : row;
      disp_nxt   = load ? pend : disp;
      mode_nxt   = load ? load_mode : mode;
      parity_nxt = parity;
      if (load && (load_mode == MODE_WIN))
         parity_nxt = 1'b0;
      else if (boundary)
         parity_nxt = !parity;

      // Pixels for the row about to be shown, from the state this same edge
      // is about to commit, so a load is visible from row 0 of the new frame.
      pixels_nxt  = row_pixels(disp_nxt, mode_nxt, row_nxt, parity_nxt);
      row_sel_nxt = (mode_nxt == MODE_IDLE) ? 8'h00 : (8'h01 << row_nxt);
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         presc      <= '0;
         row        <= 3'd0;
         parity     <= 1'b0;
         pend_full  <= 1'b0;
         pend       <= '0;
         disp       <= '0;
         mode       <= MODE_IDLE;
         row_sel    <= 8'h00;
         col_data   <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         presc      <= row_adv ? '0 : presc + PW'(1);
         row        <= row_nxt;
         parity     <= parity_nxt;
         disp       <= disp_nxt;
         mode       <= mode_nxt;
         frame_done <= boundary;

         // take and load are mutually exclusive: take needs an empty slot,
         // load needs a full one.
         if (take) begin
            pend      <= incoming;
            pend_full <= 1'b1;
         end else if (load) begin
            pend_full <= 1'b0;
         end

         if (row_adv) begin
            row_sel  <= row_sel_nxt;
            col_data <= pixels_nxt;
         end
      end
   end

endmodule

// File: tb/tb_pong_matrix_driver.sv
// Bench for pong_matrix_driver at ROW_DIV=4. A reference model counts edges
// since reset and derives row, frame boundaries and pixels arithmetically;
// every cycle the DUT outputs are compared with it, plus literal checks.
module tb_pong_matrix_driver;

   localparam int D     = 4;
   localparam int FRAME = 8 * D;
   localparam int WIN   = 7;

   logic       sys_clk = 1'b0;
   logic       reset = 1'b1;
   logic       upd_valid = 1'b0;
   logic [2:0] ball_x = 3'd0;
   logic [2:0] ball_y = 3'd0;
   logic [2:0] pad1_y = 3'd0;
   logic [2:0] pad2_y = 3'd0;
   logic [2:0] sc1 = 3'd0;
   logic [2:0] sc2 = 3'd0;
   logic       start_o = 1'b0;
   logic       upd_ready;
   logic [7:0] row_sel;
   logic [7:0] col_data;
   logic       frame_done;

   always #5 sys_clk = ~sys_clk;

   pong_matrix_driver #(.ROW_DIV(D), .WIN_SCORE(WIN)) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .pad1_y     (pad1_y),
      .pad2_y     (pad2_y),
      .sc1        (sc1),
      .sc2        (sc2),
      .start_o    (start_o),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_done (frame_done)
   );

   typedef struct {
      int bx; int by; int p1; int p2; int s1; int s2; int st;
   } gs_t;

   int  checks = 0;
   int  failures = 0;

   // model: 0 idle, 1 splash, 2 play, 3 win
   gs_t m_disp;
   gs_t m_pend;
   bit  m_pend_full;
   int  m_mode;
   bit  m_par;
   int  m_n;

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %02h expected %02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic gs_t zero_gs();
      gs_t g;
      g.bx = 0; g.by = 0; g.p1 = 0; g.p2 = 0; g.s1 = 0; g.s2 = 0; g.st = 0;
      return g;
   endfunction

   function automatic logic [7:0] exp_pix(input int r);
      logic [7:0] v;
      v = 8'h00;
      case (m_mode)
         1: v = (r % 2 == 0) ? 8'h55 : 8'hAA;
         2: begin
            for (int c = 0; c < 8; c++) begin
               if ((c == m_disp.bx && r == m_disp.by) ||
                   (c == 0 && r >= m_disp.p1 && r <= m_disp.p1 + 2) ||
                   (c == 7 && r >= m_disp.p2 && r <= m_disp.p2 + 2))
                  v[c] = 1'b1;
            end
`ifdef PONG_SCORE_OVERLAY_EN
            if (r == 0)
               v = v | 8'((m_disp.s1 << 1) | (m_disp.s2 << 4));
`endif
         end
         3: begin
            if (!m_par) begin
               if (m_disp.s1 >= WIN) v = v | 8'h0F;
               if (m_disp.s2 >= WIN) v = v | 8'hF0;
            end
         end
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // One clock: advance model across the edge, then compare all outputs.
   task automatic step();
      bit  acc;
      gs_t in_g;
      int  r;
      acc = upd_valid && !m_pend_full && !reset;
      in_g.bx = int'(ball_x); in_g.by = int'(ball_y);
      in_g.p1 = int'(pad1_y); in_g.p2 = int'(pad2_y);
      in_g.s1 = int'(sc1);    in_g.s2 = int'(sc2);
      in_g.st = int'(start_o);
      @(posedge sys_clk);
      if (reset) begin
         m_n = 0; m_pend_full = 0; m_mode = 0; m_par = 0;
         m_disp = zero_gs(); m_pend = zero_gs();
      end else begin
         m_n++;
         if (m_n % FRAME == 0) begin
            if (m_pend_full) begin
               m_disp = m_pend;
               m_pend_full = 0;
               if (m_disp.st != 0)                          m_mode = 1;
               else if (m_disp.s1 >= WIN || m_disp.s2 >= WIN) m_mode = 3;
               else                                         m_mode = 2;
               m_par = (m_mode == 3) ? 1'b0 : !m_par;
            end else begin
               m_par = !m_par;
            end
         end
         if (acc) begin
            m_pend = in_g;
            m_pend_full = 1;
         end
      end
      #1;
      r = (m_n / D) % 8;
      chk1("upd_ready", upd_ready, !m_pend_full);
      chk1("frame_done", frame_done, (m_n > 0) && (m_n % FRAME == 0));
      chk8("row_sel", row_sel, (m_mode == 0) ? 8'h00 : 8'(1 << r));
      chk8("col_data", col_data, exp_pix(r));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic offer(input int bx, input int by, input int p1, input int p2,
                        input int s1, input int s2, input int st);
      bit done;
      bit will;
      ball_x = 3'(bx); ball_y = 3'(by); pad1_y = 3'(p1); pad2_y = 3'(p2);
      sc1 = 3'(s1); sc2 = 3'(s2); start_o = st[0];
      upd_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 3 * FRAME && !done; i++) begin
         will = !m_pend_full;
         step();
         done = will;
      end
      upd_valid = 1'b0;
      chk1("offer_accepted", done, 1'b1);
   endtask

   task automatic wait_frame();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         step();
         seen = frame_done;
      end
      chk1("frame_seen", seen, 1'b1);
   endtask

   task automatic wait_row(input int r);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         step();
         seen = (row_sel === 8'(1 << r));
      end
      chk1("row_seen", seen, 1'b1);
   endtask

   initial begin
      m_n = 0; m_pend_full = 0; m_mode = 0; m_par = 0;
      m_disp = zero_gs(); m_pend = zero_gs();

      // reset and IDLE scanning
      reset = 1'b1;
      run(2);
      chk8("reset_row_sel", row_sel, 8'h00);
      chk1("reset_ready", upd_ready, 1'b1);
      reset = 1'b0;
      run(3 * FRAME);

      // playfield
      offer(2, 3, 6, 0, 0, 0, 0);
      wait_frame();
      chk8("play_row0", col_data, 8'h80);
      wait_row(3); chk8("play_row3", col_data, 8'h04);
      wait_row(5); chk8("play_row5", col_data, 8'h00);
      wait_row(6); chk8("play_row6", col_data, 8'h01);
      wait_row(7); chk8("play_row7", col_data, 8'h01);

      // back-to-back updates: second waits for the boundary
      offer(5, 5, 1, 4, 1, 2, 0);
      chk1("busy_ready_low", upd_ready, 1'b0);
      offer(0, 0, 5, 5, 2, 1, 0);
      run(2 * FRAME);

      // splash then sc2 win
      offer(0, 0, 0, 0, 0, 0, 1);
      wait_frame();
      chk8("splash_row0", col_data, 8'h55);
      run(D);
      chk8("splash_row1", col_data, 8'hAA);
      offer(1, 1, 1, 1, 2, 7, 0);
      wait_frame();
      chk8("win_even", col_data, 8'hF0);
      wait_frame();
      chk8("win_odd", col_data, 8'h00);
      wait_frame();
      chk8("win_even2", col_data, 8'hF0);

      // randomized updates with random idle gaps
      for (int k = 0; k < 30; k++) begin
         run($urandom_range(0, 40));
         offer($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
      run(2 * FRAME);

      // reset mid-frame with pending full
      offer(3, 3, 3, 3, 0, 0, 0);
      run(5);
      chk1("pre_reset_pending", upd_ready, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk8("midreset_row_sel", row_sel, 8'h00);
      chk1("midreset_ready", upd_ready, 1'b1);
      run(2 * FRAME);

      // score overlay on row 0
      offer(7, 7, 3, 3, 5, 3, 0);
      wait_frame();
`ifdef PONG_SCORE_OVERLAY_EN
      chk8("overlay_row0", col_data, 8'h3A);
`else
      chk8("overlay_row0", col_data, 8'h00);
`endif
      run(FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
